// File: rtl/traffic_light_fsm.sv
// Intersection master controller. Sequences the main/side road lamps and the
// pedestrian walk phase, and drives the external timer: each phase pulses
// start_timer with its duration on its first cycle, then waits for expired.
module traffic_light_fsm #(
  parameter logic [3:0] BASE_TIME = 4'd6,  // green duration, 1..15
  parameter logic [3:0] EXT_TIME  = 4'd3,  // side-green extension and walk duration, 1..15
  parameter logic [3:0] YEL_TIME  = 4'd2   // yellow duration, 1..15 (0 wraps the timer)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       side_sensor,
  input  logic       walk_request,
  input  logic       expired,
  output logic       start_timer,
  output logic [3:0] time_value,
  output logic       main_r,
  output logic       main_y,
  output logic       main_g,
  output logic       side_r,
  output logic       side_y,
  output logic       side_g,
  output logic       walk
);

  typedef enum logic [2:0] {
    ST_MG   = 3'd0,  // main green, side red
    ST_MY   = 3'd1,  // main yellow, side red
    ST_SG   = 3'd2,  // main red, side green
    ST_SGX  = 3'd3,  // main red, side green (single extension)
    ST_SY   = 3'd4,  // main red, side yellow
    ST_WALK = 3'd5   // all red, walk lamp on
  } state_t;

  state_t state_q, state_d;
  logic   start_q, start_d;          // high on the first cycle of every phase
  logic   side_pend_q, side_pend_d;  // side road car waiting
  logic   walk_pend_q, walk_pend_d;  // pedestrian waiting
  logic   entering_sg;
  logic   entering_walk;

  // State register, phase-start flag and demand latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values of its neighbours regardless of block order.
      state_q     <= ST_MG;
      // Armed during reset so the first cycle after release loads the timer;
      // the output gate below keeps the pulse invisible while reset is high.
      start_q     <= 1'b1;
      side_pend_q <= 1'b0;
      walk_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      side_pend_q <= side_pend_d;
      walk_pend_q <= walk_pend_d;
    end
  end

  // Next phase: expired is honoured only after the start cycle of a phase.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path through the case can leave it unassigned and infer a latch.
    state_d = state_q;
    start_d = 1'b0;
    case (state_q)
      ST_MG: begin
        if (!start_q && expired) begin
          // No demand: stay green but restart the timer.
          state_d = (side_pend_q || walk_pend_q) ? ST_MY : ST_MG;
          start_d = 1'b1;
        end
      end
      ST_MY: begin
        if (!start_q && expired) begin
          state_d = ST_SG;
          start_d = 1'b1;
        end
      end
      ST_SG: begin
        if (!start_q && expired) begin
          state_d = side_sensor ? ST_SGX : ST_SY;
          start_d = 1'b1;
        end
      end
      ST_SGX: begin
        if (!start_q && expired) begin
          state_d = ST_SY;
          start_d = 1'b1;
        end
      end
      ST_SY: begin
        if (!start_q && expired) begin
          state_d = walk_pend_q ? ST_WALK : ST_MG;
          start_d = 1'b1;
        end
      end
      ST_WALK: begin
        if (!start_q && expired) begin
          state_d = ST_MG;
          start_d = 1'b1;
        end
      end
      default: begin
        // Corrupted encoding: recover to main green with a fresh timer load.
        state_d = ST_MG;
        start_d = 1'b1;
      end
    endcase
  end

  // Demand latches: clearing on phase entry wins over a simultaneous request.
  always_comb begin
    entering_sg   = (state_d == ST_SG)   && (state_q != ST_SG);
    entering_walk = (state_d == ST_WALK) && (state_q != ST_WALK);

    side_pend_d = side_pend_q;
    if (entering_sg) begin
      side_pend_d = 1'b0;
    end else if (side_sensor && (state_q == ST_MG || state_q == ST_MY)) begin
      side_pend_d = 1'b1;
    end

    walk_pend_d = walk_pend_q;
    if (entering_walk) begin
      walk_pend_d = 1'b0;
    end else if (walk_request && (state_q != ST_WALK)) begin
      walk_pend_d = 1'b1;
    end
  end

  // Lamp and timer-duration decode from the state register.
  always_comb begin
    main_r     = 1'b0;
    main_y     = 1'b0;
    main_g     = 1'b0;
    side_r     = 1'b0;
    side_y     = 1'b0;
    side_g     = 1'b0;
    walk       = 1'b0;
    time_value = BASE_TIME;
    case (state_q)
      ST_MG: begin
        main_g     = 1'b1;
        side_r     = 1'b1;
        time_value = BASE_TIME;
      end
      ST_MY: begin
        main_y     = 1'b1;
        side_r     = 1'b1;
        time_value = YEL_TIME;
      end
      ST_SG: begin
        main_r     = 1'b1;
        side_g     = 1'b1;
        time_value = BASE_TIME;
      end
      ST_SGX: begin
        main_r     = 1'b1;
        side_g     = 1'b1;
        time_value = EXT_TIME;
      end
      ST_SY: begin
        main_r     = 1'b1;
        side_y     = 1'b1;
        time_value = YEL_TIME;
      end
      ST_WALK: begin
        main_r     = 1'b1;
        side_r     = 1'b1;
        walk       = 1'b1;
        time_value = EXT_TIME;
      end
      default: begin
        // Illegal encoding: hold everything red for the one recovery cycle.
        main_r     = 1'b1;
        side_r     = 1'b1;
        time_value = BASE_TIME;
      end
    endcase
    if (reset) begin
      time_value = BASE_TIME;
    end
  end

  // The start pulse is suppressed while reset is held; it also resets the timer.
  assign start_timer = start_q && !reset;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: a timer stand-in answers start_timer with
// expired, a phase-level model predicts lamps and timer loads every cycle,
// and directed scenarios pin the observed phase sequence to literal strings.
module tb_traffic_light_fsm;

  localparam logic [3:0] BASE = 4'd6;
  localparam logic [3:0] EXT  = 4'd3;
  localparam logic [3:0] YEL  = 4'd2;
  localparam int         TICK = 2;  // clocks per timer second

  logic       clk          = 1'b0;
  logic       reset        = 1'b1;
  logic       side_sensor  = 1'b0;
  logic       walk_request = 1'b0;
  logic       tmr_exp      = 1'b0;
  logic       inj_exp      = 1'b0;
  logic       expired;
  logic       start_timer;
  logic [3:0] time_value;
  logic       main_r, main_y, main_g, side_r, side_y, side_g, walk;

  int    errors = 0;
  int    checks = 0;
  bit    chk_en = 1'b0;
  string log_q[$];  // one label per observed start pulse

  assign expired = tmr_exp | inj_exp;

  traffic_light_fsm #(
    .BASE_TIME(BASE),
    .EXT_TIME (EXT),
    .YEL_TIME (YEL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .side_sensor (side_sensor),
    .walk_request(walk_request),
    .expired     (expired),
    .start_timer (start_timer),
    .time_value  (time_value),
    .main_r      (main_r),
    .main_y      (main_y),
    .main_g      (main_g),
    .side_r      (side_r),
    .side_y      (side_y),
    .side_g      (side_g),
    .walk        (walk)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
    end
  endtask

  // ---------------- phase-level model ----------------
  // Lamp vector order: {main_r, main_y, main_g, side_r, side_y, side_g, walk}
  function automatic logic [6:0] lamp_of(input string ph);
    if (ph == "MG")                  return 7'b0011000;
    if (ph == "MY")                  return 7'b0101000;
    if (ph == "SG" || ph == "SGX")   return 7'b1000010;
    if (ph == "SY")                  return 7'b1000100;
    return 7'b1001001;  // WK
  endfunction

  function automatic logic [3:0] dur_of(input string ph);
    if (ph == "MG" || ph == "SG") return BASE;
    if (ph == "MY" || ph == "SY") return YEL;
    return EXT;  // SGX, WK
  endfunction

  string m_ph    = "MG";
  bit    m_first = 1'b1;
  bit    m_side  = 1'b0;
  bit    m_walk  = 1'b0;
  string m_nxt;
  bit    m_go;

  always @(posedge clk) begin
    if (reset) begin
      m_ph    = "MG";
      m_first = 1'b1;
      m_side  = 1'b0;
      m_walk  = 1'b0;
    end else begin
      m_go  = !m_first && expired;
      m_nxt = m_ph;
      if (m_go) begin
        if (m_ph == "MG")       m_nxt = (m_side || m_walk) ? "MY" : "MG";
        else if (m_ph == "MY")  m_nxt = "SG";
        else if (m_ph == "SG")  m_nxt = side_sensor ? "SGX" : "SY";
        else if (m_ph == "SGX") m_nxt = "SY";
        else if (m_ph == "SY")  m_nxt = m_walk ? "WK" : "MG";
        else                    m_nxt = "MG";
      end
      if (m_go && m_nxt == "SG")                               m_side = 1'b0;
      else if (side_sensor && (m_ph == "MG" || m_ph == "MY"))  m_side = 1'b1;
      if (m_go && m_nxt == "WK")                               m_walk = 1'b0;
      else if (walk_request && m_ph != "WK")                   m_walk = 1'b1;
      m_first = m_go;
      m_ph    = m_nxt;
    end
  end

  // Label of the phase being started, taken from the DUT's own outputs.
  function automatic string label();
    if (main_g)                        return "MG";
    if (main_y)                        return "MY";
    if (side_g && time_value == EXT)   return "SGX";
    if (side_g)                        return "SG";
    if (side_y)                        return "SY";
    if (walk)                          return "WK";
    return "??";
  endfunction

  function automatic string log_str();
    string s = "";
    foreach (log_q[i]) s = (i == 0) ? log_q[i] : {s, " ", log_q[i]};
    return s;
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check($sformatf("start_timer(%s)", m_ph), 32'(start_timer), 32'(m_first && !reset));
      if ((m_first && !reset) || reset)
        check($sformatf("time_value(%s)", m_ph), 32'(time_value),
              32'(reset ? BASE : dur_of(m_ph)));
      check($sformatf("lamps(%s)", m_ph),
            32'({main_r, main_y, main_g, side_r, side_y, side_g, walk}), 32'(lamp_of(m_ph)));
      if (start_timer && !reset) log_q.push_back(label());
    end
  end

  // Timer stand-in: expired pulses TICK*time_value clocks after a start load.
  int tmr_cnt = 0;
  always begin : timer_env
    logic       st;
    logic [3:0] tv;
    logic       rs;
    @(negedge clk);
    st = start_timer;
    tv = time_value;
    rs = reset;
    @(posedge clk);
    #1;
    if (rs) begin
      tmr_cnt = 0;
      tmr_exp = 1'b0;
    end else if (st) begin
      tmr_cnt = int'(tv) * TICK;
      tmr_exp = 1'b0;
    end else if (tmr_cnt > 0) begin
      tmr_cnt--;
      tmr_exp = (tmr_cnt == 0);
    end else begin
      tmr_exp = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_log_end(input string lbl, input int min_n, input int budget);
    int n = 0;
    while (!(log_q.size() >= min_n && log_q[log_q.size() - 1] == lbl) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_%s: timed out after %0d cycles, log \"%s\"", lbl, n, log_str());
    end
  endtask

  task automatic wait_walk_lamp(input int budget);
    int n = 0;
    while (walk !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_walk: walk lamp not seen within %0d cycles", budget);
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int non_mg;

    // Reset for three clocks; state checked while reset is still held.
    step();
    chk_en = 1'b1;
    step();
    check("rst_main_g", 32'(main_g), 32'd1);
    check("rst_side_r", 32'(side_r), 32'd1);
    check("rst_walk", 32'(walk), 32'd0);
    check("rst_start", 32'(start_timer), 32'd0);
    check("rst_time_value", 32'(time_value), 32'd6);
    step();
    reset = 1'b0;
    log_q.delete();
    #1;
    check("rel_start", 32'(start_timer), 32'd1);
    check("rel_time_value", 32'(time_value), 32'd6);

    // Idle: main green repeats with a fresh 6 s load on every expiry.
    repeat (45) step();
    non_mg = 0;
    foreach (log_q[i]) if (log_q[i] != "MG") non_mg++;
    check("idle_non_mg_starts", 32'(non_mg), 32'd0);
    check("idle_restarts_ge3", 32'(log_q.size() >= 3), 32'd1);

    // Single-cycle side car: one full side cycle, no extension.
    log_q.delete();
    side_sensor = 1'b1;
    step();
    side_sensor = 1'b0;
    wait_log_end("MG", 2, 200);
    check_str("side_pulse_seq", log_str(), "MY SG SY MG");

    // Side car held through side green: exactly one extension.
    log_q.delete();
    side_sensor = 1'b1;
    wait_log_end("SY", 1, 200);
    side_sensor = 1'b0;
    wait_log_end("MG", 2, 200);
    check_str("side_held_seq", log_str(), "MY SG SGX SY MG");

    // Walk request during side green: walk phase after side yellow.
    log_q.delete();
    side_sensor = 1'b1;
    step();
    side_sensor = 1'b0;
    wait_log_end("SG", 1, 200);
    walk_request = 1'b1;
    step();
    walk_request = 1'b0;
    wait_log_end("WK", 1, 200);
    check("walk_lamp", 32'(walk), 32'd1);
    check("walk_all_red", 32'({main_r, side_r}), 32'd3);
    check("walk_time_value", 32'(time_value), 32'd3);
    wait_log_end("MG", 2, 200);
    check_str("walk_seq", log_str(), "MY SG SY WK MG");
    log_q.delete();
    wait_log_end("MG", 1, 60);
    check_str("walk_served", log_str(), "MG");

    // Request arriving on the walk entry cycle counts as already served.
    log_q.delete();
    walk_request = 1'b1;
    step();
    walk_request = 1'b0;
    wait_walk_lamp(200);
    walk_request = 1'b1;
    step();
    walk_request = 1'b0;
    wait_log_end("MG", 2, 200);
    check_str("walk_entry_seq", log_str(), "MY SG SY WK MG");
    log_q.delete();
    wait_log_end("MG", 1, 60);
    check_str("walk_entry_no_repeat", log_str(), "MG");

    // Reset in the middle of the extension, with an expired pulse during reset.
    log_q.delete();
    side_sensor = 1'b1;
    wait_log_end("SGX", 1, 200);
    step();
    step();
    side_sensor = 1'b0;
    reset       = 1'b1;
    inj_exp     = 1'b1;
    step();
    check("midrst_main_g", 32'(main_g), 32'd1);
    check("midrst_side_r", 32'(side_r), 32'd1);
    check("midrst_start", 32'(start_timer), 32'd0);
    check("midrst_time_value", 32'(time_value), 32'd6);
    inj_exp = 1'b0;
    step();
    // Release with a spurious expired in the start cycle (must be ignored).
    reset        = 1'b0;
    walk_request = 1'b1;
    inj_exp      = 1'b1;
    log_q.delete();
    #1;
    check("midrst_rel_start", 32'(start_timer), 32'd1);
    check("midrst_rel_time_value", 32'(time_value), 32'd6);
    step();
    walk_request = 1'b0;
    inj_exp      = 1'b0;
    check("spur_start_ignored", 32'(main_g), 32'd1);
    check("spur_start_waiting", 32'(start_timer), 32'd0);
    step();
    step();
    // Spurious expired in the wait phase is honoured.
    inj_exp = 1'b1;
    step();
    inj_exp = 1'b0;
    check("spur_wait_honoured", 32'(main_y), 32'd1);
    wait_log_end("MG", 2, 300);
    check_str("midrst_seq", log_str(), "MG MY SG SY WK MG");

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
